// File: rtl/add_round_key_stage.sv
// add_round_key_stage: AES AddRoundKey stage placed after mixColumns.
// Holds NR+1 round keys, loaded one 32-bit word at a time. Each accepted state
// is XORed with the key of the current round and registered behind a
// valid/ready handshake.
// Valid/ready rule: a beat moves when valid && ready are both high at a rising
// clock edge. A producer holds its data stable while valid is high and ready is low.
// Build option ADD_ROUND_KEY_SKID_EN: when defined, a 2-entry skid buffer is used
// and in_ready comes from a register, so it has no combinational path from out_ready.
module add_round_key_stage #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_wr_en,
    input  logic [5:0]   key_wr_addr,
    input  logic [31:0]  key_wr_data,
    input  logic         key_clear,
    output logic         key_loaded,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_first,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic [3:0]   out_round,
    output logic         out_last
);
    localparam int         NW         = 4 * (NR + 1);
    localparam logic [6:0] NW_L       = 7'(NW);
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    logic [31:0]   key_mem [NW];
    logic [NW-1:0] mask_q, mask_d;
    logic          key_loaded_q, key_loaded_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          wr_acc;
    logic          accept;
    logic [3:0]    round_sel;
    logic [5:0]    rk_base;
    logic [127:0]  round_key;
    // A beat is packed as {last, round[3:0], state[127:0]}.
    logic [132:0]  new_beat;
    logic          out_valid_q, out_valid_d;
    logic [132:0]  out_beat_q, out_beat_d;

    assign key_loaded = key_loaded_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_beat_q[132];
    assign out_round  = out_beat_q[131:128];
    assign out_state  = out_beat_q[127:0];
    assign accept     = in_valid && in_ready;

    // Key words are written only while unloaded, in range, and not being cleared.
    always_comb begin
        wr_acc = key_wr_en && !key_loaded_q && !key_clear && ({1'b0, key_wr_addr} < NW_L);
    end

    // Key store has no reset; it holds valid data only once key_loaded is set.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            key_mem[key_wr_addr] <= key_wr_data;
        end
    end

    // Pick the round, read its four key words, and form the outgoing beat.
    always_comb begin
        round_sel = in_first ? 4'd0 : cnt_q;
        rk_base   = {round_sel, 2'b00};
        round_key = {key_mem[rk_base], key_mem[rk_base + 6'd1],
                     key_mem[rk_base + 6'd2], key_mem[rk_base + 6'd3]};
        new_beat  = {(round_sel == LAST_ROUND), round_sel, in_state ^ round_key};
    end

    // Write mask, loaded flag and round counter. A clear overrides everything else.
    always_comb begin
        mask_d       = mask_q;
        key_loaded_d = &mask_q;
        cnt_d        = cnt_q;
        if (wr_acc) begin
            mask_d[key_wr_addr] = 1'b1;
        end
        if (accept) begin
            cnt_d = (round_sel == LAST_ROUND) ? 4'd0 : round_sel + 4'd1;
        end
        if (key_clear) begin
            mask_d       = '0;
            key_loaded_d = 1'b0;
            cnt_d        = 4'd0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q       <= '0;
            key_loaded_q <= 1'b0;
            cnt_q        <= 4'd0;
        end else begin
            mask_q       <= mask_d;
            key_loaded_q <= key_loaded_d;
            cnt_q        <= cnt_d;
        end
    end

`ifdef ADD_ROUND_KEY_SKID_EN
    logic         skid_valid_q, skid_valid_d;
    logic [132:0] skid_beat_q, skid_beat_d;
    logic         in_ready_q, in_ready_d;

    assign in_ready = in_ready_q;

    // Output and skid steering. A beat that arrives during a stall goes into the skid slot.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_beat_d   = out_beat_q;
        skid_valid_d = skid_valid_q;
        skid_beat_d  = skid_beat_q;
        if (skid_valid_q) begin
            if (out_ready) begin
                out_beat_d   = skid_beat_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_beat_d  = new_beat;
            end else begin
                skid_valid_d = 1'b1;
                skid_beat_d  = new_beat;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        in_ready_d = key_loaded_d && !skid_valid_d;
    end

    // Output, skid and ready registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_beat_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_beat_q  <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_beat_q   <= out_beat_d;
            skid_valid_q <= skid_valid_d;
            skid_beat_q  <= skid_beat_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    assign in_ready = key_loaded_q && (!out_valid_q || out_ready);

    // Single output register: load on accept, otherwise empty it when downstream takes it.
    always_comb begin
        out_valid_d = out_valid_q;
        out_beat_d  = out_beat_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_beat_d  = new_beat;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_beat_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_beat_q  <= out_beat_d;
        end
    end
`endif

endmodule

// File: tb/tb_add_round_key_stage.sv
// tb_add_round_key_stage: randomized bench for the AddRoundKey stage, using a
// behavioural AES key schedule and round model.
module tb_add_round_key_stage;
    localparam int NR = 10;
    localparam int NW = 4 * (NR + 1);
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk;
    logic         rst_n;
    logic         key_wr_en;
    logic [5:0]   key_wr_addr;
    logic [31:0]  key_wr_data;
    logic         key_clear;
    logic         key_loaded;
    logic         in_valid;
    logic         in_ready;
    logic         in_first;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic [3:0]   out_round;
    logic         out_last;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0]  w_model [NW];
    logic [127:0] rk_model [NR+1];
    int           model_cnt = 0;
    logic [132:0] exp_q[$];

    add_round_key_stage #(.NR(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_wr_en(key_wr_en), .key_wr_addr(key_wr_addr), .key_wr_data(key_wr_data),
        .key_clear(key_clear), .key_loaded(key_loaded),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_round(out_round), .out_last(out_last)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // AES arithmetic for the reference key schedule.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        for (int i = 1; i < 256; i++) begin
            if (gmul(a, 8'(i)) == 8'h01) inv = 8'(i);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w_model[i] = key[127-32*i -: 32];
        for (int i = 4; i < NW; i++) begin
            t = w_model[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t = t ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w_model[i] = w_model[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++)
            rk_model[r] = {w_model[4*r], w_model[4*r+1], w_model[4*r+2], w_model[4*r+3]};
    endtask

    // Reference beat: the round is 0 on a first beat, otherwise the next round in the block.
    function automatic logic [132:0] model_beat(input logic f, input logic [127:0] s);
        int r;
        r = f ? 0 : model_cnt;
        model_cnt = (r == NR) ? 0 : r + 1;
        return {(r == NR), 4'(r), s ^ rk_model[r]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Driver tasks.
    task automatic write_word(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        key_wr_en = 1'b1; key_wr_addr = a; key_wr_data = d;
        @(posedge clk); #1;
        key_wr_en = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < NW; i++) write_word(6'(i), w_model[i]);
        repeat (2) @(negedge clk);
    endtask

    // One cycle: drive inputs at the falling edge, then sample what the next rising edge will see.
    task automatic step(input logic v, input logic f, input logic [127:0] s, input logic ordy,
                        output logic acc, output logic ov, output logic [132:0] ob);
        @(negedge clk);
        in_valid = v; in_first = f; in_state = s; out_ready = ordy;
        #1;
        acc = v && in_ready;
        ov  = out_valid;
        ob  = {out_last, out_round, out_state};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({key_loaded, in_ready, out_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset flags: got %b want 000", {key_loaded, in_ready, out_valid});
        end
        n_cmp++;
        if ({out_last, out_round, out_state} !== 133'd0) begin
            n_fail++;
            $display("FAIL reset data: got %h want 0", {out_last, out_round, out_state});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_key_load();
        write_word(6'd5, 32'hdeadbeef);
        write_word(6'd50, $urandom);
        for (int i = 0; i < NW; i++) begin
            write_word(6'(i), w_model[i]);
            if (i == NW - 2) begin
                n_cmp++;
                if (key_loaded !== 1'b0) begin
                    n_fail++;
                    $display("FAIL key_load early: key_loaded got %b want 0", key_loaded);
                end
            end
        end
        @(negedge clk);
        n_cmp++;
        if (key_loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL key_load delay: key_loaded got %b want 0", key_loaded);
        end
        @(negedge clk);
        n_cmp++;
        if ({key_loaded, in_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL key_load done: {key_loaded,in_ready} got %b want 11", {key_loaded, in_ready});
        end
    endtask

    task automatic test_fips();
        logic acc, ov;
        logic [132:0] ob;
        write_word(6'd0, 32'h0);
        step(1'b1, 1'b1, 128'h3243f6a8885a308d313198a2e0370734, 1'b1, acc, ov, ob);
        void'(model_beat(1'b1, 128'h3243f6a8885a308d313198a2e0370734));
        n_cmp++;
        if (acc !== 1'b1) begin
            n_fail++;
            $display("FAIL fips accept: in_ready got %b want 1", acc);
        end
        step(1'b1, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, acc, ov, ob);
        void'(model_beat(1'b0, 128'h046681e5e0cb199a48f8d37a2806264c));
        n_cmp++;
        if ({ov, ob} !== {1'b1, 1'b0, 4'd0, 128'h193de3bea0f4e22b9ac68d2ae9f84808}) begin
            n_fail++;
            $display("FAIL fips round0: got %h want 1_0_0_193de3bea0f4e22b9ac68d2ae9f84808", {ov, ob});
        end
        step(1'b0, 1'b0, 128'd0, 1'b1, acc, ov, ob);
        n_cmp++;
        if ({ov, ob} !== {1'b1, 1'b0, 4'd1, 128'ha49c7ff2689f352b6b5bea43026a5049}) begin
            n_fail++;
            $display("FAIL fips round1: got %h want 1_0_1_a49c7ff2689f352b6b5bea43026a5049", {ov, ob});
        end
        step(1'b0, 1'b0, 128'd0, 1'b1, acc, ov, ob);
    endtask

    task automatic test_rounds();
        logic acc, ov;
        logic [132:0] ob, exp;
        logic [127:0] s;
        int seen;
        seen = 0;
        for (int c = 0; c < 14; c++) begin
            s = rand128();
            step(c < 12, c == 0, s, 1'b1, acc, ov, ob);
            if (c < 12) begin
                n_cmp++;
                if (acc !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rounds throughput beat %0d: accept got %b want 1", c, acc);
                end
            end
            if (acc) exp_q.push_back(model_beat(c == 0, s));
            if (ov) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rounds extra beat: got %h want none", ob);
                end else begin
                    exp = exp_q.pop_front();
                    if (ob !== exp) begin
                        n_fail++;
                        $display("FAIL rounds data: got %h want %h", ob, exp);
                    end
                end
                n_cmp++;
                if (ob[131:128] !== 4'(seen % 11) || ob[132] !== (seen % 11 == 10)) begin
                    n_fail++;
                    $display("FAIL rounds index beat %0d: got round %0d last %b want round %0d last %b",
                             seen, ob[131:128], ob[132], seen % 11, (seen % 11 == 10));
                end
                seen++;
            end
        end
        n_cmp++;
        if (seen != 12) begin
            n_fail++;
            $display("FAIL rounds count: got %0d want 12", seen);
        end
    endtask

    task automatic test_stall();
        logic acc, ov, ordy, p_ov, p_rdy;
        logic [132:0] ob, exp, p_ob;
        logic [127:0] s;
        int sent, got;
        sent = 0; got = 0; p_ov = 1'b0; p_rdy = 1'b1; p_ob = '0;
        s = rand128();
        for (int c = 0; c < 80 && !(sent == 20 && exp_q.size() == 0); c++) begin
            ordy = !(c >= 6 && c < 11);
            step(sent < 20, sent == 0, s, ordy, acc, ov, ob);
            if (p_ov && !p_rdy) begin
                n_cmp++;
                if (!ov || ob !== p_ob) begin
                    n_fail++;
                    $display("FAIL stall hold: got %b_%h want 1_%h", ov, ob, p_ob);
                end
            end
            if (acc) begin
                exp_q.push_back(model_beat(sent == 0, s));
                sent++;
                s = rand128();
            end
            if (ov && ordy) begin
                n_cmp++;
                got++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stall extra beat: got %h want none", ob);
                end else begin
                    exp = exp_q.pop_front();
                    if (ob !== exp) begin
                        n_fail++;
                        $display("FAIL stall data: got %h want %h", ob, exp);
                    end
                end
            end
            p_ov = ov; p_rdy = ordy; p_ob = ob;
        end
        n_cmp++;
        if (got != 20 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall count: got %0d beats (%0d pending) want 20 (0 pending)", got, exp_q.size());
        end
    endtask

    task automatic test_random();
        logic acc, ov, ordy, p_valid, p_first, p_ov, p_rdy;
        logic [132:0] ob, exp, p_ob;
        logic [127:0] p_state;
        p_valid = 1'b0; p_first = 1'b0; p_state = '0;
        p_ov = 1'b0; p_rdy = 1'b1; p_ob = '0;
        for (int c = 0; c < 440 && !(c >= 400 && exp_q.size() == 0); c++) begin
            if (!p_valid && c < 400 && $urandom_range(0, 3) != 0) begin
                p_valid = 1'b1;
                p_first = ($urandom_range(0, 15) == 0);
                p_state = rand128();
            end
            ordy = (c >= 400) || ($urandom_range(0, 3) != 0);
            step(p_valid, p_first, p_state, ordy, acc, ov, ob);
            if (p_ov && !p_rdy) begin
                n_cmp++;
                if (!ov || ob !== p_ob) begin
                    n_fail++;
                    $display("FAIL random hold: got %b_%h want 1_%h", ov, ob, p_ob);
                end
            end
            if (acc) begin
                exp_q.push_back(model_beat(p_first, p_state));
                p_valid = 1'b0;
            end
            if (ov && ordy) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL random extra beat: got %h want none", ob);
                end else begin
                    exp = exp_q.pop_front();
                    if (ob !== exp) begin
                        n_fail++;
                        $display("FAIL random data: got %h want %h", ob, exp);
                    end
                end
            end
            p_ov = ov; p_rdy = ordy; p_ob = ob;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random drain: pending got %0d want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_clear();
        logic acc, ov;
        logic [132:0] ob, exp;
        logic [127:0] s;
        s = rand128();
        step(1'b1, 1'b1, s, 1'b0, acc, ov, ob);
        if (acc) exp_q.push_back(model_beat(1'b1, s));
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        key_clear = 1'b1; key_wr_en = 1'b1; key_wr_addr = 6'd0; key_wr_data = 32'hdeadbeef;
        @(posedge clk); #1;
        key_clear = 1'b0; key_wr_en = 1'b0;
        model_cnt = 0;
        @(negedge clk);
        n_cmp++;
        if ({key_loaded, in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL clear flags: {key_loaded,in_ready} got %b want 00", {key_loaded, in_ready});
        end
        step(1'b0, 1'b0, 128'd0, 1'b1, acc, ov, ob);
        n_cmp++;
        if (!ov || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL clear kept beat: out_valid got %b want 1 (%0d expected)", ov, exp_q.size());
        end else begin
            exp = exp_q.pop_front();
            if (ob !== exp) begin
                n_fail++;
                $display("FAIL clear kept beat data: got %h want %h", ob, exp);
            end
        end
        step(1'b0, 1'b0, 128'd0, 1'b1, acc, ov, ob);
        n_cmp++;
        if (ov !== 1'b0) begin
            n_fail++;
            $display("FAIL clear drained: out_valid got %b want 0", ov);
        end
        exp_q.delete();
        expand_key(rand128());
        for (int i = 1; i < NW; i++) write_word(6'(i), w_model[i]);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (key_loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL clear dropped write: key_loaded got %b want 0", key_loaded);
        end
        write_word(6'd0, w_model[0]);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (key_loaded !== 1'b1) begin
            n_fail++;
            $display("FAIL clear reload: key_loaded got %b want 1", key_loaded);
        end
        s = rand128();
        step(1'b1, 1'b0, s, 1'b1, acc, ov, ob);
        if (acc) exp_q.push_back(model_beat(1'b0, s));
        step(1'b0, 1'b0, 128'd0, 1'b1, acc, ov, ob);
        n_cmp++;
        if (!ov || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL clear counter beat: out_valid got %b want 1", ov);
        end else begin
            exp = exp_q.pop_front();
            if (ob !== exp || ob[131:128] !== 4'd0) begin
                n_fail++;
                $display("FAIL clear counter: got %h want %h (round 0)", ob, exp);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic acc, ov;
        logic [132:0] ob, exp;
        logic [127:0] s;
        step(1'b1, 1'b1, rand128(), 1'b0, acc, ov, ob);
        step(1'b1, 1'b0, rand128(), 1'b0, acc, ov, ob);
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({key_loaded, in_ready, out_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid flags: got %b want 000", {key_loaded, in_ready, out_valid});
        end
        n_cmp++;
        if ({out_last, out_round, out_state} !== 133'd0) begin
            n_fail++;
            $display("FAIL reset_mid data: got %h want 0", {out_last, out_round, out_state});
        end
        exp_q.delete();
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        load_all();
        n_cmp++;
        if (key_loaded !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid reload: key_loaded got %b want 1", key_loaded);
        end
        s = rand128();
        step(1'b1, 1'b0, s, 1'b1, acc, ov, ob);
        if (acc) exp_q.push_back(model_beat(1'b0, s));
        step(1'b0, 1'b0, 128'd0, 1'b1, acc, ov, ob);
        n_cmp++;
        if (!ov || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL reset_mid beat: out_valid got %b want 1", ov);
        end else begin
            exp = exp_q.pop_front();
            if (ob !== exp || ob[131:128] !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_mid counter: got %h want %h (round 0)", ob, exp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        key_wr_en = 1'b0; key_wr_addr = '0; key_wr_data = '0; key_clear = 1'b0;
        in_valid = 1'b0; in_first = 1'b0; in_state = '0; out_ready = 1'b0;
        expand_key(FIPS_KEY);
        test_reset();
        test_key_load();
        test_fips();
        test_rounds();
        test_stall();
        test_random();
        test_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
